// File: rtl/logic_unit_nand_pipe.sv
// rtl/logic_unit_nand_pipe.sv - two-stage pipelined bitwise logic unit built from 2-input NAND cells
module logic_unit_nand_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             op_err,
    output logic [CNT_W-1:0] txn_count
);

    function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
        return ~(x & z);
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d, ones_q, ones_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic s2_ready, s1_ready, in_fire, out_fire;

    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_fire  = in_valid && s1_ready;
    assign out_fire = s2_valid_q && out_ready;

    // Gate network evaluated on the stage-1 registers
    logic [WIDTH-1:0] n_ab, n_a, n_b, and_w, or_w, nor_w, x_a, x_b, xor_w, xnor_w;
    logic [WIDTH-1:0] res;

    assign n_ab   = nand2(a_q, b_q);
    assign n_a    = nand2(a_q, a_q);
    assign n_b    = nand2(b_q, b_q);
    assign and_w  = nand2(n_ab, n_ab);
    assign or_w   = nand2(n_a, n_b);
    assign nor_w  = nand2(or_w, or_w);
    assign x_a    = nand2(a_q, n_ab);
    assign x_b    = nand2(b_q, n_ab);
    assign xor_w  = nand2(x_a, x_b);
    assign xnor_w = nand2(xor_w, xor_w);

    always_comb begin
        res = '0;
        case (op_q)
            3'd0:    res = n_a;
            3'd1:    res = and_w;
            3'd2:    res = or_w;
            3'd3:    res = nor_w;
            3'd4:    res = xor_w;
            3'd5:    res = xnor_w;
            3'd6:    res = n_ab;
            default: res = '0;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_fire) begin
            a_d  = a;
            b_d  = b;
            op_d = op;
        end
    end

    // Stage 2 only loads when it can hand off its current content, so stalls hold y/flags
    always_comb begin
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        zero_d     = zero_q;
        ones_d     = ones_q;
        err_d      = err_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d    = res;
                zero_d = (res == '0);
                ones_d = &res;
                err_d  = (op_q == 3'd7);
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            y_q        <= '0;
            zero_q     <= 1'b0;
            ones_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            zero_q     <= zero_d;
            ones_q     <= ones_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign op_err    = err_q;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_nand_pipe.sv
// tb/tb_logic_unit_nand_pipe.sv - scoreboard bench for logic_unit_nand_pipe (8-bit unit plus 1-bit/2-bit-counter unit)
module tb_logic_unit_nand_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, y;
    logic [2:0] op;
    logic       zero, ones, op_err;
    logic [15:0] txn_count;

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic       a1, b1, y1, zero1, ones1, err1;
    logic [2:0] op1;
    logic [1:0] cnt1;

    logic_unit_nand_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .ones(ones), .op_err(op_err), .txn_count(txn_count)
    );

    logic_unit_nand_pipe #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op(op1), .out_valid(out_valid1), .out_ready(out_ready1),
        .y(y1), .zero(zero1), .ones(ones1), .op_err(err1), .txn_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] z, input logic [2:0] o);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & z;
            3'd2:    return x | z;
            3'd3:    return ~(x | z);
            3'd4:    return x ^ z;
            3'd5:    return ~(x ^ z);
            3'd6:    return ~(x & z);
            default: return 8'h00;
        endcase
    endfunction

    typedef struct {
        logic [7:0] y;
        logic       zero;
        logic       ones;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        sbq1[$];
    int          cyc = 0;
    int          n_acc = 0;
    int          n_out = 0;
    logic [15:0] exp_cnt = '0;
    logic [1:0]  exp_cnt1 = '0;
    bit          lat_check = 0;
    bit          stall_prev = 0;
    logic [7:0]  stall_y;
    logic        stall_z, stall_o, stall_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t make_exp(input logic [7:0] x, input logic [7:0] z, input logic [2:0] o, input int w);
        exp_t e;
        logic [7:0] r, mask;
        mask   = (w >= 8) ? 8'hFF : 8'((1 << w) - 1);
        r      = ref_op(x, z, o) & mask;
        e.y    = r;
        e.zero = (r == 8'h00);
        e.ones = (r == mask);
        e.err  = (o == 3'd7);
        e.cyc  = cyc;
        return e;
    endfunction

    // Monitor for the 8-bit unit: pop on transfer, check counter and stall stability
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("txn_count", txn_count, exp_cnt);
            if (out_valid) begin
                if (stall_prev) begin
                    chk("stall_y", y, stall_y);
                    chk("stall_flags", {zero, ones, op_err}, {stall_z, stall_o, stall_e});
                end
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("y", y, e.y);
                        chk("zero", zero, e.zero);
                        chk("ones", ones, e.ones);
                        chk("op_err", op_err, e.err);
                        if (lat_check) chk("latency", cyc - e.cyc, 2);
                    end
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                    n_out++;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_y = y; stall_z = zero; stall_o = ones; stall_e = op_err;
            if (in_valid && in_ready) begin
                sbq.push_back(make_exp(a, b, op, 8));
                n_acc++;
            end
        end
    end

    // Monitor for the 1-bit unit with a 2-bit counter
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("cnt1", cnt1, exp_cnt1);
            if (out_valid1 && out_ready1) begin
                if (sbq1.size() == 0) begin
                    chk("unexpected_out1", 1, 0);
                end else begin
                    e = sbq1.pop_front();
                    chk("y1", y1, e.y[0]);
                    chk("flags1", {zero1, ones1, err1}, {e.zero, e.ones, e.err});
                    chk("zero_xor_ones1", zero1 ^ ones1, 1);
                end
                if (exp_cnt1 != 2'd3) exp_cnt1 = exp_cnt1 + 2'd1;
            end
            if (in_valid1 && in_ready1) sbq1.push_back(make_exp({7'b0, a1}, {7'b0, b1}, op1, 1));
        end
    end

    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top);
        bit ok;
        ok = 0;
        a = ta; b = tb; op = top; in_valid = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && (sbq.size() != 0 || out_valid); c++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        int idx, start_acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = 1'b0; b1 = 1'b0; op1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_flags", {zero, ones, op_err}, 0);
        chk("rst_txn_count", txn_count, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Directed sweep of ops 0..6 on F0/3C
        lat_check = 1;
        for (int i = 0; i < 7; i++) send(8'hF0, 8'h3C, 3'(i));
        drain();
        chk("t1_count", txn_count, 7);
        lat_check = 0;

        // Illegal op
        send(8'hFF, 8'hFF, 3'd7);
        drain();
        chk("t2_count", txn_count, 8);

        // Backpressure: only two transactions fit while the output is blocked
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 6));
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        chk("t3_accepts", idx, 2);
        chk("t3_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 50 && idx < 4; c++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 3'($urandom_range(0, 6));
            @(negedge clk);
            if (in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        chk("t3_count", txn_count, 12);

        // Random traffic with random backpressure
        start_acc = n_acc;
        for (int c = 0; c < 20000 && (n_acc - start_acc) < 1000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            op        = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("t4_accepts", n_acc - start_acc, 1000);
        drain();
        chk("t4_count", txn_count, n_out);

        // 1-bit unit: five transactions saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            in_valid1 = 1'b1; a1 = 1'($urandom); b1 = 1'($urandom); op1 = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
        end
        in_valid1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t5_sat", cnt1, 3);
        chk("t5_empty", sbq1.size(), 0);

        // Reset with two transactions in flight
        send(8'h12, 8'h34, 3'd4);
        send(8'h56, 8'h78, 3'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_txn_count", txn_count, 0);
        sbq.delete(); sbq1.delete();
        exp_cnt = '0; exp_cnt1 = '0; stall_prev = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("t6_in_ready", in_ready, 1);
        send(8'hA5, 8'h0F, 3'd5);
        drain();
        chk("t6_count", txn_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
